// File: rtl/const_mult_pipe.sv
// const_mult_pipe: P = K*Y, one LW-bit limb of Y folded in per stage, K run-time loadable.
// Latency NL cycles from accept to out_valid; one operand per cycle while out_ready is high.
// Backpressure: whole pipe freezes while a result waits at the output; in_ready drops combinationally.
// Optional: define CMULT_TAG_EN to carry a TAG_W sideband tag (in_tag/out_tag) alongside each operand.
module const_mult_pipe #(
  parameter int KW = 256,
  parameter int YW = 128,                   // must be a multiple of LW, with YW/LW >= 2
  parameter int LW = 32,
  parameter logic [KW-1:0] K_INIT = 256'h92e5c273477d21d8361651a6eea3cb5b1c424d77f1b750a99cc6df2b0ee713a2,
  parameter int TAG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [YW-1:0]    Y,
  input  logic             k_load,
  input  logic [KW-1:0]    k_in,
  output logic             k_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KW+YW-1:0] P
`ifdef CMULT_TAG_EN
  ,
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag
`endif
);

  localparam int NL = YW / LW;
  localparam int PW = KW + YW;

  logic [NL-1:0] r_vld;
  logic [PW-1:0] r_acc [NL];
  // Y shifted right by one limb per stage, so the limb needed by stage s+1 sits at bit 0 of r_y[s]
  logic [YW-1:0] r_y   [NL-1];
  logic [KW-1:0] r_k;
  logic [PW-1:0] w_sum [NL];
  logic          w_adv;
  logic          w_unused;

  // Every stage moves together; only a result stuck at the output can stop the pipe.
  assign w_adv     = !r_vld[NL-1] || out_ready;
  assign in_ready  = w_adv;
  // K may only change with nothing in flight and nothing arriving, so each operand sees one K.
  assign k_ready   = !(|r_vld) && !in_valid;
  assign out_valid = r_vld[NL-1];
  assign P         = r_acc[NL-1];
  // Upper bits of the last carried Y are all zeros after the shifts and never consumed.
  assign w_unused  = ^r_y[NL-2][YW-1:LW];

  // Partial products: stage 0 uses the low limb of the incoming Y, later stages the carried limb.
  always_comb begin
    w_sum    = '{default: '0};
    w_sum[0] = PW'(r_k) * PW'(Y[LW-1:0]);
    for (int s = 1; s < NL; s++) begin
      w_sum[s] = r_acc[s-1] + ((PW'(r_k) * PW'(r_y[s-1][LW-1:0])) << (s * LW));
    end
  end

  // Stage registers: valid, accumulator and carried limbs shift in lockstep on advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      for (int s = 0; s < NL; s++) r_acc[s] <= '0;
      for (int s = 0; s < NL - 1; s++) r_y[s] <= '0;
    end else if (w_adv) begin
      r_vld <= {r_vld[NL-2:0], in_valid};
      for (int s = 0; s < NL; s++) r_acc[s] <= w_sum[s];
      r_y[0] <= Y >> LW;
      for (int s = 1; s < NL - 1; s++) r_y[s] <= r_y[s-1] >> LW;
    end
  end

  // Constant register: a load is taken only when k_ready says the pipe is empty and idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_k <= K_INIT;
    end else if (k_load && k_ready) begin
      r_k <= k_in;
    end
  end

`ifdef CMULT_TAG_EN
  logic [TAG_W-1:0] r_tag [NL];

  assign out_tag = r_tag[NL-1];

  // Tag pipe mirrors the valid pipe so each tag leaves with its own product.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NL; s++) r_tag[s] <= '0;
    end else if (w_adv) begin
      r_tag[0] <= in_tag;
      for (int s = 1; s < NL; s++) r_tag[s] <= r_tag[s-1];
    end
  end
`else
  logic [TAG_W-1:0] w_unused_tag;
  assign w_unused_tag = '0;
`endif

endmodule

// File: tb/tb_const_mult_pipe.sv
// Directed bench for const_mult_pipe: latency, streaming, stall, K reload, async reset, optional tag.
module tb_const_mult_pipe;
  localparam int KW = 256;
  localparam int YW = 128;
  localparam int LW = 32;
  localparam int PW = KW + YW;
  localparam int TAG_W = 8;
  localparam logic [KW-1:0] K_INIT = 256'h92e5c273477d21d8361651a6eea3cb5b1c424d77f1b750a99cc6df2b0ee713a2;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [YW-1:0] Y;
  logic          k_load;
  logic [KW-1:0] k_in;
  logic          k_ready;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] P;
`ifdef CMULT_TAG_EN
  logic [TAG_W-1:0] in_tag;
  logic [TAG_W-1:0] out_tag;
`endif

  int n_vec = 0;
  int n_err = 0;

  const_mult_pipe #(.KW(KW), .YW(YW), .LW(LW), .K_INIT(K_INIT), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .Y(Y),
    .k_load(k_load), .k_in(k_in), .k_ready(k_ready),
    .out_valid(out_valid), .out_ready(out_ready), .P(P)
`ifdef CMULT_TAG_EN
    , .in_tag(in_tag), .out_tag(out_tag)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [PW-1:0] ref_mul(input logic [KW-1:0] k, input logic [YW-1:0] y);
    return PW'(k) * PW'(y);
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; Y = '0; k_load = 1'b0; k_in = '0; out_ready = 1'b1;
`ifdef CMULT_TAG_EN
    in_tag = '0;
`endif
    repeat (2) @(negedge clock);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (P !== '0) begin n_err++; $display("FAIL reset_P: got %h want 0", P); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (k_ready !== 1'b1) begin n_err++; $display("FAIL reset_k_ready: got %b want 1", k_ready); end
`ifdef CMULT_TAG_EN
    n_vec++; if (out_tag !== '0) begin n_err++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
`endif
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    logic [YW-1:0] ys [3];
    logic [PW-1:0] ex [3];
    logic          want_v;
    ys[0] = '0; ys[1] = 128'd1; ys[2] = {1'b1, 127'b0};
    ex[0] = '0; ex[1] = PW'(K_INIT); ex[2] = PW'(K_INIT) << 127;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      in_valid = (i < 3);
      if (i < 3) Y = ys[i]; else Y = '0;
      out_ready = 1'b1;
      #1;
      want_v = (i >= 4 && i <= 6);
      n_vec++; if (out_valid !== want_v) begin n_err++; $display("FAIL basic_out_valid cyc%0d: got %b want %b", i, out_valid, want_v); end
      if (want_v) begin
        n_vec++; if (P !== ex[i-4]) begin n_err++; $display("FAIL basic_P%0d: got %h want %h", i-4, P, ex[i-4]); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [YW-1:0] ys [30];
    logic [PW-1:0] ex [30];
    int ii = 0, oi = 0, first = -1, last = -1;
    ys[0] = '1; ys[1] = {32{4'hA}}; ys[2] = {32{4'h5}};
    for (int i = 3; i < 30; i++) ys[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 30; i++) ex[i] = ref_mul(K_INIT, ys[i]);
    for (int c = 0; c < 100 && oi < 30; c++) begin
      @(negedge clock);
      in_valid = (ii < 30);
      if (ii < 30) Y = ys[ii]; else Y = '0;
      out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) ii++;
      if (out_valid) begin
        n_vec++; if (P !== ex[oi]) begin n_err++; $display("FAIL b2b_P%0d: got %h want %h", oi, P, ex[oi]); end
        if (first < 0) first = c;
        last = c;
        oi++;
      end
    end
    in_valid = 1'b0;
    n_vec++; if (oi != 30) begin n_err++; $display("FAIL b2b_count: got %0d want 30", oi); end
    n_vec++; if (last - first != 29) begin n_err++; $display("FAIL b2b_gapless: span %0d want 29", last - first); end
  endtask

  task automatic test_stall();
    logic [YW-1:0] ys [6];
    logic [PW-1:0] ex [6];
    int ii = 0, oi = 0;
    ys[0] = 128'd7; ys[1] = 128'hFFFF_FFFF; ys[2] = 128'd1 << 32;
    ys[3] = 128'd1 << 64; ys[4] = 128'd1 << 96; ys[5] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
    for (int i = 0; i < 6; i++) ex[i] = ref_mul(K_INIT, ys[i]);
    for (int c = 0; c < 40 && oi < 6; c++) begin
      @(negedge clock);
      in_valid = (ii < 6);
      if (ii < 6) Y = ys[ii]; else Y = '0;
      out_ready = !(c >= 4 && c <= 6);
      #1;
      if (c >= 4 && c <= 6) begin
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc%0d: got %b want 0", c, in_ready); end
        n_vec++; if (out_valid !== 1'b1 || P !== ex[oi]) begin
          n_err++; $display("FAIL stall_hold cyc%0d: valid %b P %h want 1 %h", c, out_valid, P, ex[oi]);
        end
      end
      if (c == 7) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_resume_in_ready: got %b want 1", in_ready); end
      end
      if (in_valid && in_ready) ii++;
      if (out_valid && out_ready) begin
        n_vec++; if (P !== ex[oi]) begin n_err++; $display("FAIL stall_P%0d: got %h want %h", oi, P, ex[oi]); end
        oi++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (oi != 6) begin n_err++; $display("FAIL stall_count: got %0d want 6", oi); end
  endtask

  task automatic test_kload();
    logic [YW-1:0] ys [2];
    logic [PW-1:0] ex [2];
    int oi = 0;
    bit found = 0;
    ys[0] = 128'd3; ys[1] = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    for (int i = 0; i < 2; i++) ex[i] = ref_mul(K_INIT, ys[i]);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      in_valid = (c < 2);
      if (c < 2) Y = ys[c]; else Y = '0;
      k_load = (c < 6); k_in = 256'd3; out_ready = 1'b1;
      #1;
      if (c < 6) begin
        n_vec++; if (k_ready !== 1'b0) begin n_err++; $display("FAIL kload_busy_k_ready cyc%0d: got %b want 0", c, k_ready); end
      end
      if (out_valid && oi < 2) begin
        n_vec++; if (P !== ex[oi]) begin n_err++; $display("FAIL kload_unchanged_P%0d: got %h want %h", oi, P, ex[oi]); end
        oi++;
      end
    end
    n_vec++; if (oi != 2) begin n_err++; $display("FAIL kload_count: got %0d want 2", oi); end
    @(negedge clock);
    in_valid = 1'b0; k_load = 1'b1; k_in = 256'd3;
    #1;
    n_vec++; if (k_ready !== 1'b1) begin n_err++; $display("FAIL kload_idle_k_ready: got %b want 1", k_ready); end
    @(negedge clock);
    k_load = 1'b0; k_in = '0; in_valid = 1'b1; Y = 128'd5;
    #1;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clock);
      in_valid = 1'b0; Y = '0;
      #1;
      if (out_valid) begin
        found = 1;
        n_vec++; if (P !== 384'd15) begin n_err++; $display("FAIL kload_P15: got %h want f", P); end
      end
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL kload_timeout: got no result want 1"); end
  endtask

  task automatic test_reset_mid();
    logic want_v;
    @(negedge clock);
    in_valid = 1'b1; Y = 128'd1; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; Y = '0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    n_vec++; if (P !== '0) begin n_err++; $display("FAIL rstmid_P: got %h want 0", P); end
    n_vec++; if (in_ready !== 1'b1 || k_ready !== 1'b1) begin
      n_err++; $display("FAIL rstmid_ready: got in %b k %b want 1 1", in_ready, k_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_stale cyc%0d: got %b want 0", c, out_valid); end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      in_valid = (i == 0);
      Y = (i == 0) ? 128'd1 : '0;
      #1;
      want_v = (i == 4);
      n_vec++; if (out_valid !== want_v) begin n_err++; $display("FAIL rstmid_kinit_valid cyc%0d: got %b want %b", i, out_valid, want_v); end
      if (want_v) begin
        n_vec++; if (P !== PW'(K_INIT)) begin n_err++; $display("FAIL rstmid_kinit_P: got %h want %h", P, PW'(K_INIT)); end
      end
    end
    in_valid = 1'b0;
  endtask

`ifdef CMULT_TAG_EN
  task automatic test_tag();
    int ii = 0, oi = 0;
    logic [PW-1:0] want_p;
    for (int c = 0; c < 40 && oi < 5; c++) begin
      @(negedge clock);
      in_valid = (ii < 5);
      Y = (ii < 5) ? YW'(ii + 11) : '0;
      in_tag = (ii < 5) ? TAG_W'(ii + 1) : '0;
      out_ready = !(c >= 5 && c <= 6);
      #1;
      want_p = ref_mul(K_INIT, YW'(oi + 11));
      if (!out_ready) begin
        n_vec++; if (out_valid !== 1'b1 || out_tag !== TAG_W'(oi + 1) || P !== want_p) begin
          n_err++; $display("FAIL tag_stall cyc%0d: valid %b tag %h want 1 %h", c, out_valid, out_tag, TAG_W'(oi + 1));
        end
      end
      if (in_valid && in_ready) ii++;
      if (out_valid && out_ready) begin
        n_vec++; if (out_tag !== TAG_W'(oi + 1) || P !== want_p) begin
          n_err++; $display("FAIL tag_out%0d: tag %h P %h want %h %h", oi, out_tag, P, TAG_W'(oi + 1), want_p);
        end
        oi++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (oi != 5) begin n_err++; $display("FAIL tag_count: got %0d want 5", oi); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_kload();
    test_reset_mid();
`ifdef CMULT_TAG_EN
    test_tag();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/const_mult_pipe.md
# const_mult_pipe

Parametrised pipelined multiplier that computes P = K × Y. K is a wide, run-time-loadable constant and Y is a streamed operand, fed as one operand per cycle. It generalises the fixed 256×128 constant-Karatsuba datapath to configurable widths and limb counts. It adds ready/valid backpressure, a guarded constant-reload port, and an optional sideband tag. It sits between operand producers and the modular reduction stage of the modular-multiplier datapath.

## Interface
- KW, 256, width of constant K (bits)
- YW, 128, width of operand Y; must be a multiple of LW
- LW, 32, limb width; NL = YW/LW pipeline stages
- K_INIT, 256'h92e5c273477d21d8361651a6eea3cb5b1c424d77f1b750a99cc6df2b0ee713a2, reset value of K register
- TAG_W, 8, tag width (used only with CMULT_TAG_EN)
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  Y operand valid
- in_ready  output  1  pipeline can accept an operand this cycle
- Y  input  YW  operand
- k_load  input  1  request to replace K with k_in
- k_in  input  KW  new constant
- k_ready  output  1  k_load is honoured this cycle
- out_valid  output  1  P valid
- out_ready  input  1  downstream accepts P
- P  output  KW+YW  product K×Y
- in_tag / out_tag  input/output  TAG_W  sideband tag (only with CMULT_TAG_EN)

## Operation
- Y is split into limbs y[s] = Y[(s+1)·LW-1 : s·LW], for s = 0..NL-1.
- Stage registers st[0..NL-1] each hold: a valid bit, the accumulator acc (KW+YW bits), the remaining Y limbs, and the tag.
- On accept (in_valid && in_ready): st[0].acc ← K·y[0].
- On each advance: st[s].acc ← st[s-1].acc + ((K·y[s]) << s·LW).
- All arithmetic is unsigned and full width. The final sum fits KW+YW bits exactly, so no truncation ever occurs.
- P = st[NL-1].acc and out_valid = st[NL-1].valid. There is no separate output register.
- Global advance: adv = !st[NL-1].valid || out_ready. All stages shift together when adv = 1 and hold when adv = 0.
- in_ready = adv. A bubble, meaning a cycle with no valid input while adv = 1, enters st[0] with valid = 0.
- Results leave in strict input order. Nothing is dropped or duplicated.
- k_ready = 1 when no st[s].valid is set and in_valid = 0.
- When k_load && k_ready, K ← k_in at the edge. Otherwise k_load is ignored with no side effect.
- The K change is visible to the first operand accepted on the following cycle or later. In-flight operands therefore always see a single K.
- A cycle with both in_valid and k_load asserted: the operand is accepted and k_load is ignored (k_ready = 0).

## Timing
- Latency: an operand accepted at edge t gives P with out_valid at the output after edge t+NL-1, i.e. NL cycles from accept. Default NL = 4.
- Throughput is 1 operand per cycle while out_ready = 1.
- When out_ready is held low with st[NL-1] valid, the pipeline freezes and in_ready = 0 in the same cycle (combinational).
- When out_ready returns high, transfer resumes that cycle.
- P and out_tag are stable while out_valid && !out_ready.
- Reset, asserted asynchronously (including mid-operation):
  - all stage valid bits clear, so out_valid = 0
  - P = 0 and all acc = 0
  - out_tag = 0
  - K = K_INIT
  - in_ready = 1 and k_ready = 1 after reset (in_valid = 0)
- In-flight operands are discarded on reset and are not replayed.

## Configuration
- CMULT_TAG_EN defined:
  - in_tag and out_tag ports exist.
  - Each stage carries TAG_W tag bits, so out_tag accompanies the matching P with identical latency and stall behaviour.
- CMULT_TAG_EN undefined:
  - Tag ports and tag registers are absent.
  - Datapath timing and behaviour are otherwise identical.

## Test plan
- Y = 0, then Y = 1, then Y = 2^127, back-to-back with K_INIT and out_ready = 1 → after NL cycles, P = 0, K_INIT, and K_INIT << 127 on consecutive cycles.
- 30 back-to-back operands (all-ones, 0xAAAA…, 0x5555…, random) → every P equals the reference K_INIT×Y, in order, with no gaps.
- 6 back-to-back operands with out_ready low for 3 cycles once the first result reaches the output:
  - in_ready drops in the same cycle out_ready drops
  - P is held stable while stalled
  - all 6 results are delivered in order with none lost
- k_load = 1 with k_in = 3 while the pipeline is busy → k_ready = 0 and K is unchanged. After the drain, k_load with k_in = 3, then Y = 5 → P = 15.
- Reset asserted 2 cycles after accepting Y = 1 → out_valid = 0 immediately and K = K_INIT. No stale P appears after reset deasserts.
- With CMULT_TAG_EN: tags 0x01..0x05 on 5 operands with a stall mid-stream → out_tag matches each P in order.
